// File: rtl/fp_accumulator.sv
// fp_accumulator: sums N_TERMS single-precision terms per result through an external stb/ack adder.
// Optional ACC_ZERO_SKIP_EN: non-first +/-0 terms are counted but bypass the adder.
`default_nettype none

module fp_accumulator #(
  parameter int N_TERMS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_stb,
  output logic        in_ack,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_a_stb,
  output logic        add_b_stb,
  input  logic        add_a_ack,
  input  logic        add_b_ack,
  input  logic [31:0] add_z,
  input  logic        add_z_stb,
  output logic        add_z_ack,
  output logic [31:0] out_sum,
  output logic        out_stb,
  input  logic        out_ack
);

  typedef enum logic [2:0] {
    GET_TERM = 3'd0,
    SEND_A   = 3'd1,
    SEND_B   = 3'd2,
    WAIT_Z   = 3'd3,
    PUT_SUM  = 3'd4
  } state_t;

  localparam logic [7:0] N_CNT = 8'(N_TERMS);

  state_t      state, state_nxt;
  logic [7:0]  term_cnt, cnt_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] term, term_nxt;
  logic        in_hs;

  assign add_a = acc;
  assign add_b = term;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = term_cnt;
    acc_nxt   = acc;
    term_nxt  = term;
    in_hs     = 1'b0;
    case (state)
      GET_TERM: begin
        if (in_stb && in_ack) begin
          in_hs   = 1'b1;
          cnt_nxt = term_cnt + 8'd1;
          if (term_cnt == 8'd0) begin
            acc_nxt   = in_data;
            state_nxt = (cnt_nxt == N_CNT) ? PUT_SUM : GET_TERM;
          end
`ifdef ACC_ZERO_SKIP_EN
          else if (in_data[30:0] == 31'd0) begin
            state_nxt = (cnt_nxt == N_CNT) ? PUT_SUM : GET_TERM;
          end
`endif
          else begin
            term_nxt  = in_data;
            state_nxt = SEND_A;
          end
        end
      end
      SEND_A: if (add_a_stb && add_a_ack) state_nxt = SEND_B;
      SEND_B: if (add_b_stb && add_b_ack) state_nxt = WAIT_Z;
      WAIT_Z: begin
        if (add_z_stb && add_z_ack) begin
          acc_nxt   = add_z;
          state_nxt = (term_cnt == N_CNT) ? PUT_SUM : GET_TERM;
        end
      end
      PUT_SUM: begin
        if (out_stb && out_ack) begin
          cnt_nxt   = 8'd0;
          state_nxt = GET_TERM;
        end
      end
      default: state_nxt = GET_TERM;
    endcase
  end

  // Handshake outputs are registered from the next state; in_ack also drops for
  // one cycle after a transfer that stays in GET_TERM (first term of a group).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= GET_TERM;
      term_cnt  <= 8'd0;
      acc       <= 32'd0;
      term      <= 32'd0;
      in_ack    <= 1'b0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
      add_z_ack <= 1'b0;
      out_stb   <= 1'b0;
      out_sum   <= 32'd0;
    end else begin
      state     <= state_nxt;
      term_cnt  <= cnt_nxt;
      acc       <= acc_nxt;
      term      <= term_nxt;
      in_ack    <= (state_nxt == GET_TERM) && !in_hs;
      add_a_stb <= (state_nxt == SEND_A);
      add_b_stb <= (state_nxt == SEND_B);
      add_z_ack <= (state_nxt == WAIT_Z);
      out_stb   <= (state_nxt == PUT_SUM);
      if (state_nxt == PUT_SUM) out_sum <= acc_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: N_TERMS=4 instance driven by a table-based adder model,
// plus an N_TERMS=1 instance that must never touch its adder port.
`default_nettype none

module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          vec = 0;
  int          miss = 0;

  // N_TERMS=4 instance
  logic [31:0] in_data = '0, add_a, add_b, add_z = '0, out_sum;
  logic        in_stb = 0, in_ack, add_a_stb, add_b_stb, add_a_ack = 0, add_b_ack = 0;
  logic        add_z_stb = 0, add_z_ack, out_stb, out_ack = 0;

  // N_TERMS=1 instance
  logic [31:0] in_data1 = '0, add_a1, add_b1, out_sum1;
  logic [31:0] add_z1 = '0;
  logic        in_stb1 = 0, in_ack1, add_a_stb1, add_b_stb1, add_z_ack1, out_stb1, out_ack1 = 0;
  logic        add_a_ack1 = 0, add_b_ack1 = 0, add_z_stb1 = 0;
  logic        seen_a1 = 0;

  // adder model state
  int          ad_st = 0, wcnt = 0, dly = 0, n_add = 0;
  logic        z_hold = 0;
  logic [31:0] a_op = '0, b_op = '0, hold_v = '0;

  always #5 clk = ~clk;

  fp_accumulator #(.N_TERMS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack), .add_z(add_z), .add_z_stb(add_z_stb),
    .add_z_ack(add_z_ack), .out_sum(out_sum), .out_stb(out_stb), .out_ack(out_ack)
  );

  fp_accumulator #(.N_TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_stb(in_stb1), .in_ack(in_ack1),
    .add_a(add_a1), .add_b(add_b1), .add_a_stb(add_a_stb1), .add_b_stb(add_b_stb1),
    .add_a_ack(add_a_ack1), .add_b_ack(add_b_ack1), .add_z(add_z1), .add_z_stb(add_z_stb1),
    .add_z_ack(add_z_ack1), .out_sum(out_sum1), .out_stb(out_stb1), .out_ack(out_ack1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vec++;
    miss++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  // Hand-computed single-precision sums for the operand pairs the vectors produce.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: fadd = 32'h40400000;
      {32'h40400000, 32'h40400000}: fadd = 32'h40C00000;
      {32'h40C00000, 32'h40800000}: fadd = 32'h41200000;
      {32'h3F800000, 32'h3F800000}: fadd = 32'h40000000;
      {32'h40000000, 32'h3F800000}: fadd = 32'h40400000;
      {32'h40400000, 32'h3F800000}: fadd = 32'h40800000;
      {32'h3F800000, 32'h00000000}: fadd = 32'h3F800000;
      {32'h3F800000, 32'h80000000}: fadd = 32'h3F800000;
      default:                      fadd = 32'hDEADBEEF;
    endcase
  endfunction

  // Adder model: acts on falling edges, so the DUT sees its outputs at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      ad_st = 0; wcnt = 0; add_a_ack = 0; add_b_ack = 0; add_z_stb = 0;
    end else begin
      case (ad_st)
        0: if (add_a_ack) begin
             add_a_ack = 0; ad_st = 1; wcnt = 0;
           end else if (add_a_stb) begin
             if (wcnt == 0) hold_v = add_a; else check("add_a_stable", add_a, hold_v);
             if (wcnt >= dly) begin add_a_ack = 1; a_op = add_a; n_add++; end
             else wcnt++;
           end
        1: if (add_b_ack) begin
             add_b_ack = 0; ad_st = 2; wcnt = 0;
           end else if (add_b_stb) begin
             if (wcnt == 0) hold_v = add_b; else check("add_b_stable", add_b, hold_v);
             if (wcnt >= dly) begin add_b_ack = 1; b_op = add_b; end
             else wcnt++;
           end
        2: if (!z_hold) begin
             add_z = fadd(a_op, b_op); add_z_stb = 1;
             ad_st = add_z_ack ? 4 : 3;
           end
        3: if (add_z_ack) ad_st = 4;
        default: begin add_z_stb = 0; ad_st = 0; end
      endcase
    end
    if (add_a_stb1) seen_a1 = 1;
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    step;
    in_data = d; in_stb = 1; n = 0;
    while (!in_ack && n < 300) begin step; n++; end
    if (n >= 300) timeout("in_ack_wait");
    step;
    in_stb = 0;
  endtask

  task automatic get_sum(input string tag, input logic [31:0] exp, input int hold);
    int n;
    n = 0;
    while (!out_stb && n < 500) begin step; n++; end
    if (n >= 500) timeout({tag, "_out_stb_wait"});
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_stb"}, {31'd0, out_stb}, 32'd1);
      check({tag, "_hold_sum"}, out_sum, exp);
      check({tag, "_hold_in_ack"}, {31'd0, in_ack}, 32'd0);
      step;
    end
    check({tag, "_sum"}, out_sum, exp);
    out_ack = 1;
    step;
    out_ack = 0;
    check({tag, "_stb_drop"}, {31'd0, out_stb}, 32'd0);
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) step;
    check("rst_in_ack", {31'd0, in_ack}, 32'd0);
    check("rst_a_stb", {31'd0, add_a_stb}, 32'd0);
    check("rst_b_stb", {31'd0, add_b_stb}, 32'd0);
    check("rst_z_ack", {31'd0, add_z_ack}, 32'd0);
    check("rst_out_stb", {31'd0, out_stb}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_sum1", out_sum1, 32'd0);
    rst = 1;
    step;

    // 1+2+3+4 = 10, then out_ack withheld for 10 cycles
    n_add = 0;
    send(32'h3F800000); send(32'h40000000); send(32'h40400000); send(32'h40800000);
    get_sum("sum10", 32'h41200000, 10);
    check("sum10_adds", n_add, 32'd3);

    // slow adder acks
    dly = 5; n_add = 0;
    repeat (4) send(32'h3F800000);
    get_sum("slow4", 32'h40800000, 0);
    check("slow4_adds", n_add, 32'd3);
    dly = 0;

    // signed zeros in the middle of a group
    n_add = 0;
    send(32'h3F800000); send(32'h00000000); send(32'h80000000); send(32'h40000000);
    get_sum("zeros", 32'h40400000, 0);
`ifdef ACC_ZERO_SKIP_EN
    check("zeros_adds", n_add, 32'd1);
`else
    check("zeros_adds", n_add, 32'd3);
`endif

    // reset while waiting on the adder result
    z_hold = 1;
    send(32'h3F800000); send(32'h40000000);
    n = 0;
    while (!add_z_ack && n < 200) begin step; n++; end
    if (n >= 200) timeout("z_ack_wait");
    rst = 0;
    step;
    rst = 1;
    z_hold = 0;
    check("mid_rst_in_ack", {31'd0, in_ack}, 32'd0);
    check("mid_rst_a_stb", {31'd0, add_a_stb}, 32'd0);
    check("mid_rst_b_stb", {31'd0, add_b_stb}, 32'd0);
    check("mid_rst_z_ack", {31'd0, add_z_ack}, 32'd0);
    check("mid_rst_out_stb", {31'd0, out_stb}, 32'd0);
    n_add = 0;
    repeat (4) send(32'h3F800000);
    get_sum("post_rst", 32'h40800000, 0);
    check("post_rst_adds", n_add, 32'd3);

    // N_TERMS=1 pass-through
    step;
    in_data1 = 32'h40490FDB; in_stb1 = 1; n = 0;
    while (!in_ack1 && n < 100) begin step; n++; end
    if (n >= 100) timeout("n1_in_ack_wait");
    step;
    in_stb1 = 0;
    n = 0;
    while (!out_stb1 && n < 100) begin step; n++; end
    if (n >= 100) timeout("n1_out_stb_wait");
    check("n1_sum", out_sum1, 32'h40490FDB);
    out_ack1 = 1;
    step;
    out_ack1 = 0;
    check("n1_stb_drop", {31'd0, out_stb1}, 32'd0);
    check("n1_no_add", {31'd0, seen_a1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

`default_nettype wire
